// File: rtl/ppu_vram_ctrl_if.sv
// Request/response bus between a PPU-side client and the VRAM controller.
interface ppu_vram_ctrl_if;
  logic        req;
  logic        wr;
  logic [13:0] addr;
  logic [7:0]  din;
  logic [1:0]  mirror_mode;
  logic        mirror_wr;
  logic        ready;
  logic [7:0]  dout;
  logic        dout_valid;

  modport master (
    output req, wr, addr, din, mirror_mode, mirror_wr,
    input  ready, dout, dout_valid
  );

  modport slave (
    input  req, wr, addr, din, mirror_mode, mirror_wr,
    output ready, dout, dout_valid
  );
endinterface

// File: rtl/ppu_vram_ctrl.sv
// PPU VRAM controller: pattern, mirrored nametable and palette memories behind a
// one-cycle request port, with an optional clear sweep of nametable/palette after reset.
module ppu_vram_ctrl #(
  parameter bit         CHR_RAM      = 1'b1,
  parameter logic [1:0] MIRROR_RESET = 2'b00,
  parameter bit         INIT_CLEAR   = 1'b1
) (
  input logic            clk,
  input logic            rst,
  ppu_vram_ctrl_if.slave bus
);

  typedef enum logic {INIT, RUN} state_e;

  state_e      state_q;
  logic [10:0] initCnt_q;
  logic        ready_q;
  logic        doutValid_q;
  logic [7:0]  dout_q;
  logic [1:0]  mode_q;

  logic [7:0] patMem [8192];
  logic [7:0] ntMem  [2048];
  logic [7:0] palMem [32];

  logic        accept;
  logic        isPat;
  logic        isPal;
  logic        isNt;
  logic        ntPage;
  logic [10:0] ntIdx;
  logic [4:0]  palIdx;
  logic [7:0]  rdData_d;
  logic        patWe;
  logic        ntWe;
  logic        palWe;
  logic [10:0] ntWaddr;
  logic [4:0]  palWaddr;
  logic [7:0]  wrData;

  // Gating with rst keeps the port closed during the very first reset cycle too.
  assign bus.ready      = ready_q & ~rst;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = doutValid_q;

  assign accept = bus.req & bus.ready;
  assign isPat  = ~bus.addr[13];
  assign isPal  = (bus.addr[13:8] == 6'h3F);
  assign isNt   = bus.addr[13] & ~isPal;

  always_comb begin
    ntPage = 1'b0;
    case (mode_q)
      2'b00:   ntPage = bus.addr[11];
      2'b01:   ntPage = bus.addr[10];
      2'b10:   ntPage = 1'b0;
      default: ntPage = 1'b1;
    endcase
  end

  assign ntIdx = {ntPage, bus.addr[9:0]};
  // Sprite backdrop slots 0x10/14/18/1C share storage with 0x00/04/08/0C.
  assign palIdx = {bus.addr[4] & (bus.addr[1:0] != 2'b00), bus.addr[3:0]};

  always_comb begin
    if (isPat)      rdData_d = patMem[bus.addr[12:0]];
    else if (isPal) rdData_d = palMem[palIdx];
    else            rdData_d = ntMem[ntIdx];
  end

  // The clear sweep owns the nametable/palette write port while in INIT.
  always_comb begin
    patWe    = 1'b0;
    ntWe     = 1'b0;
    palWe    = 1'b0;
    ntWaddr  = ntIdx;
    palWaddr = palIdx;
    wrData   = bus.din;
    if (state_q == INIT && !rst) begin
      ntWe     = 1'b1;
      palWe    = 1'b1;
      ntWaddr  = initCnt_q;
      palWaddr = initCnt_q[4:0];
      wrData   = 8'h00;
    end else if (accept && bus.wr) begin
      patWe = isPat & CHR_RAM;
      ntWe  = isNt;
      palWe = isPal;
    end
  end

  always_ff @(posedge clk) begin
    if (patWe) patMem[bus.addr[12:0]] <= wrData;
    if (ntWe)  ntMem[ntWaddr]         <= wrData;
    if (palWe) palMem[palWaddr]       <= wrData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT_CLEAR ? INIT : RUN;
      initCnt_q   <= 11'd0;
      ready_q     <= ~INIT_CLEAR;
      dout_q      <= 8'h00;
      doutValid_q <= 1'b0;
      mode_q      <= MIRROR_RESET;
    end else begin
      if (bus.mirror_wr) mode_q <= bus.mirror_mode;
      doutValid_q <= accept & ~bus.wr;
      if (accept && !bus.wr) dout_q <= rdData_d;
      case (state_q)
        INIT: begin
          initCnt_q <= initCnt_q + 11'd1;
          if (initCnt_q == 11'd2047) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        default: ready_q <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_vram_ctrl.sv
// Self-checking bench for ppu_vram_ctrl: directed vector table, multi-cycle reset
// sequences and randomized traffic against an address-arithmetic reference model.
module tb_ppu_vram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cmpCount  = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  ppu_vram_ctrl_if busA();
  ppu_vram_ctrl_if busR();

  ppu_vram_ctrl #(.CHR_RAM(1'b1), .MIRROR_RESET(2'b00), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(busA)
  );

  ppu_vram_ctrl #(.CHR_RAM(1'b0), .MIRROR_RESET(2'b01), .INIT_CLEAR(1'b0)) dutRom (
    .clk(clk), .rst(rst), .bus(busR)
  );

  // Reference model of the main instance, in plain PPU address arithmetic.
  logic [7:0] patM [8192];
  logic [7:0] ntM  [2048];
  logic [7:0] palM [32];
  logic [1:0] mMode   = 2'b00;
  int         mInit   = 2048;
  bit         mValid  = 1'b0;
  logic [7:0] mDout   = 8'h00;

  function automatic int ntIndex(input int a, input logic [1:0] m);
    int off;
    int quad;
    int page;
    off  = (a - 'h2000) % 'h1000;
    quad = off / 'h400;
    case (m)
      2'b00:   page = quad / 2;
      2'b01:   page = quad % 2;
      2'b10:   page = 0;
      default: page = 1;
    endcase
    return page * 'h400 + off % 'h400;
  endfunction

  function automatic int palIndex(input int a);
    int i;
    i = a % 32;
    if (i % 4 == 0) i = i % 16;
    return i;
  endfunction

  function automatic logic [7:0] modelRead(input int a);
    if (a < 'h2000)       return patM[a];
    else if (a >= 'h3F00) return palM[palIndex(a)];
    else                  return ntM[ntIndex(a, mMode)];
  endfunction

  function automatic void modelWrite(input int a, input logic [7:0] d);
    if (a < 'h2000)       patM[a] = d;
    else if (a >= 'h3F00) palM[palIndex(a)] = d;
    else                  ntM[ntIndex(a, mMode)] = d;
  endfunction

  function automatic void modelStep();
    bit acc;
    if (rst) begin
      mMode  = 2'b00;
      mInit  = 2048;
      mValid = 1'b0;
      mDout  = 8'h00;
    end else begin
      acc    = busA.req && (mInit == 0);
      mValid = 1'b0;
      if (acc && !busA.wr) begin
        mValid = 1'b1;
        mDout  = modelRead(int'(busA.addr));
      end
      if (acc && busA.wr) modelWrite(int'(busA.addr), busA.din);
      if (busA.mirror_wr) mMode = busA.mirror_mode;
      if (mInit > 0) begin
        mInit--;
        if (mInit == 0) begin
          for (int k = 0; k < 2048; k++) ntM[k] = 8'h00;
          for (int k = 0; k < 32; k++) palM[k] = 8'h00;
        end
      end
    end
  endfunction

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
    cmpCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    modelStep();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit r, input bit rq, input bit w, input logic [13:0] a,
                               input logic [7:0] d, input bit mw, input logic [1:0] mm);
    rst              = r;
    busA.req         = rq;
    busA.wr          = w;
    busA.addr        = a;
    busA.din         = d;
    busA.mirror_wr   = mw;
    busA.mirror_mode = mm;
    busR.req         = 1'b0;
    busR.mirror_wr   = 1'b0;
    tick();
  endtask

  task automatic applyRom(input bit rq, input bit w, input logic [13:0] a, input logic [7:0] d);
    busA.req       = 1'b0;
    busA.mirror_wr = 1'b0;
    busR.req       = rq;
    busR.wr        = w;
    busR.addr      = a;
    busR.din       = d;
    tick();
  endtask

  task automatic checkOutput(input string name, input bit expValid, input logic [7:0] expDout);
    compare({name, "_valid"}, 32'(busA.dout_valid), 32'(expValid));
    compare({name, "_dout"}, 32'(busA.dout), 32'(expDout));
  endtask

  task automatic checkReady(input string name, input bit exp);
    compare(name, 32'(busA.ready), 32'(exp));
  endtask

  // Runs the clear sweep with reads pending; all of them must be dropped.
  task automatic countInit(input string name);
    int low;
    bit sawValid;
    low      = 0;
    sawValid = 1'b0;
    while (!busA.ready && low < 3000) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 14'h2000, 8'h00, 1'b0, 2'b00);
      low++;
      if (busA.dout_valid) sawValid = 1'b1;
    end
    compare({name, "_lowCycles"}, 32'(low), 32'd2048);
    compare({name, "_droppedReq"}, 32'(sawValid), 32'd0);
  endtask

  typedef struct {
    bit         req;
    bit         wr;
    logic [13:0] addr;
    logic [7:0] din;
    bit         mwr;
    logic [1:0] mm;
    bit         expValid;
    logic [7:0] expDout;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input bit rq, input bit w, input logic [13:0] a, input logic [7:0] d,
                                 input bit mw, input logic [1:0] mm, input bit ev, input logic [7:0] ed);
    vec_t v;
    v.req = rq; v.wr = w; v.addr = a; v.din = d;
    v.mwr = mw; v.mm = mm; v.expValid = ev; v.expDout = ed;
    vecs.push_back(v);
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish within its time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] romBefore;
    logic [13:0] ra;
    int region;

    busA.req = 1'b0; busA.wr = 1'b0; busA.addr = '0; busA.din = '0;
    busA.mirror_wr = 1'b0; busA.mirror_mode = 2'b00;
    busR.req = 1'b0; busR.wr = 1'b0; busR.addr = '0; busR.din = '0;
    busR.mirror_wr = 1'b0; busR.mirror_mode = 2'b00;

    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0, 2'b00);
    checkOutput("reset", 1'b0, 8'h00);
    checkReady("reset_ready", 1'b0);

    countInit("init");
    checkReady("init_done_ready", 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 14'h2000, 8'h00, 1'b0, 2'b00);
    checkOutput("clr_nt", 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 14'h3F1F, 8'h00, 1'b0, 2'b00);
    checkOutput("clr_pal", 1'b1, 8'h00);

    // Mirroring, palette aliasing, pattern write, back-to-back reads with a mode switch.
    addVec(0, 0, 14'h0000, 8'h00, 1, 2'b01, 0, 8'h00);
    addVec(1, 1, 14'h2005, 8'hA5, 0, 2'b00, 0, 8'h00);
    addVec(1, 0, 14'h2805, 8'h00, 0, 2'b00, 1, 8'hA5);
    addVec(1, 0, 14'h2405, 8'h00, 0, 2'b00, 1, 8'h00);
    addVec(0, 0, 14'h0000, 8'h00, 1, 2'b00, 0, 8'h00);
    addVec(1, 0, 14'h2405, 8'h00, 0, 2'b00, 1, 8'hA5);
    addVec(1, 1, 14'h3F10, 8'h3C, 0, 2'b00, 0, 8'hA5);
    addVec(1, 0, 14'h3F00, 8'h00, 0, 2'b00, 1, 8'h3C);
    addVec(1, 1, 14'h3F14, 8'h11, 0, 2'b00, 0, 8'h3C);
    addVec(1, 0, 14'h3F04, 8'h00, 0, 2'b00, 1, 8'h11);
    addVec(1, 0, 14'h3F11, 8'h00, 0, 2'b00, 1, 8'h00);
    addVec(1, 1, 14'h0123, 8'h77, 0, 2'b00, 0, 8'h00);
    addVec(1, 0, 14'h0123, 8'h00, 0, 2'b00, 1, 8'h77);
    addVec(1, 1, 14'h2000, 8'h01, 0, 2'b00, 0, 8'h77);
    addVec(1, 1, 14'h2001, 8'h02, 0, 2'b00, 0, 8'h77);
    addVec(1, 1, 14'h2002, 8'h03, 0, 2'b00, 0, 8'h77);
    addVec(1, 1, 14'h2C02, 8'h33, 0, 2'b00, 0, 8'h77);
    addVec(1, 0, 14'h2000, 8'h00, 0, 2'b00, 1, 8'h01);
    addVec(1, 0, 14'h2001, 8'h00, 1, 2'b11, 1, 8'h02);
    addVec(1, 0, 14'h2002, 8'h00, 0, 2'b00, 1, 8'h33);
    addVec(0, 0, 14'h0000, 8'h00, 0, 2'b00, 0, 8'h33);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1'b0, vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].mwr, vecs[i].mm);
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expDout);
    end

    for (int i = 0; i < 64; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, 14'(i), 8'($urandom), 1'b0, 2'b00);

    for (int i = 0; i < 400; i++) begin
      region = int'($urandom_range(0, 2));
      case (region)
        0:       ra = 14'($urandom_range(0, 63));
        1:       ra = 14'('h2000 + $urandom_range(0, 'h1EFF));
        default: ra = 14'('h3F00 + $urandom_range(0, 255));
      endcase
      applyStimulus(1'b0, $urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), ra, 8'($urandom),
                    $urandom_range(0, 9) == 0, 2'($urandom));
      checkOutput($sformatf("rand%0d", i), mValid, mDout);
    end

    applyStimulus(1'b0, 1'b1, 1'b0, 14'h0123, 8'h00, 1'b0, 2'b00);
    checkOutput("pre_rst_read", 1'b1, 8'h77);
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0123, 8'h00, 1'b0, 2'b00);
    checkOutput("rst_inflight", 1'b0, 8'h00);
    checkReady("rst_ready", 1'b0);

    begin
      bit sawReady;
      bit sawValid;
      sawReady = 1'b0;
      sawValid = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        applyStimulus(1'b0, 1'b1, 1'b0, 14'h2400, 8'h00, 1'b0, 2'b00);
        if (busA.ready) sawReady = 1'b1;
        if (busA.dout_valid) sawValid = 1'b1;
      end
      compare("midinit_ready", 32'(sawReady), 32'd0);
      compare("midinit_valid", 32'(sawValid), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0, 2'b00);
    countInit("reinit");

    applyStimulus(1'b0, 1'b1, 1'b0, 14'h2000, 8'h00, 1'b0, 2'b00);
    checkOutput("reinit_nt", 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 14'h3F00, 8'h00, 1'b0, 2'b00);
    checkOutput("reinit_pal", 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 14'h0123, 8'h00, 1'b0, 2'b00);
    checkOutput("pat_kept", 1'b1, 8'h77);
    applyStimulus(1'b0, 1'b1, 1'b1, 14'h2400, 8'h99, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b1, 1'b0, 14'h2000, 8'h00, 1'b0, 2'b00);
    checkOutput("mode_reset_horiz", 1'b1, 8'h99);

    // Read-only pattern memory on the second instance, which starts in vertical mode.
    compare("rom_ready", 32'(busR.ready), 32'd1);
    applyRom(1'b1, 1'b0, 14'h0123, 8'h00);
    compare("rom_read0_valid", 32'(busR.dout_valid), 32'd1);
    romBefore = busR.dout;
    applyRom(1'b1, 1'b1, 14'h0123, 8'h77);
    compare("rom_write_valid", 32'(busR.dout_valid), 32'd0);
    applyRom(1'b1, 1'b0, 14'h0123, 8'h00);
    compare("rom_read1_valid", 32'(busR.dout_valid), 32'd1);
    compare("rom_unchanged", 32'(busR.dout), 32'(romBefore));
    compare("rom_not_written", 32'(busR.dout == 8'h77 && romBefore != 8'h77), 32'd0);
    applyRom(1'b1, 1'b1, 14'h2005, 8'h5A);
    applyRom(1'b1, 1'b0, 14'h2805, 8'h00);
    compare("rom_vert_dout", 32'(busR.dout), 32'h5A);
    applyRom(1'b0, 1'b0, 14'h0000, 8'h00);
    compare("rom_idle_valid", 32'(busR.dout_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule

// File: doc/ppu_vram_ctrl.md
PPU_VRAM_CTRL -- requirements
Module: ppu_vram_ctrl

Interface
REQ-001 Parameter CHR_RAM, default 1: 1 makes pattern memory writable; 0 makes it read-only, with writes ignored.
REQ-002 Parameter MIRROR_RESET, default 2'b00: mirroring mode loaded on reset.
REQ-003 Parameter INIT_CLEAR, default 1: 1 zero-fills nametable and palette memory after reset.
REQ-004 clk  in  1  system clock; the block has one clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 req  in  1  access request; accepted when req=1 and ready=1 at a clock edge.
REQ-007 wr  in  1  1=write, 0=read; sampled with req.
REQ-008 addr  in  14  PPU address.
REQ-009 din  in  8  write data.
REQ-010 mirror_mode  in  2  encoding: 00=horizontal, 01=vertical, 10=one-screen A, 11=one-screen B.
REQ-011 mirror_wr  in  1  loads mirror_mode into the internal mode register.
REQ-012 ready  out  1  block can accept a request.
REQ-013 dout  out  8  read data.
REQ-014 dout_valid  out  1  one-cycle pulse marking dout as new read data.

Function
REQ-015 Decode 0x0000-0x1FFF to pattern memory of 8192x8, indexed by addr[12:0].
REQ-016 Decode 0x2000-0x3EFF to nametable memory of 2048x8 at {page, addr[9:0]}.
REQ-017 Nametable page select: horizontal page=addr[11]; vertical page=addr[10]; one-screen A page=0; one-screen B page=1.
REQ-018 Decode 0x3F00-0x3FFF to palette memory of 32x8 at addr[4:0], with bit4 forced to 0 when addr[1:0]=00 (0x3F10/14/18/1C alias 0x3F00/04/08/0C), for both reads and writes.
REQ-019 Accepted read: dout and dout_valid=1 appear at the next clock edge (latency 1).
REQ-020 dout holds its last read value until the next accepted read.
REQ-021 dout_valid is 0 in every cycle not immediately following an accepted read.
REQ-022 Accepted write: the target memory is updated at the accepting edge, and dout_valid=0 in the next cycle.
REQ-023 A read accepted in the cycle after a write to the same location returns the written data.
REQ-024 When CHR_RAM=0, writes to 0x0000-0x1FFF are ignored, with no memory change and no error.
REQ-025 A request presented while ready=0 is dropped: no memory access and no dout_valid.
REQ-026 The mode register is loaded when mirror_wr=1.
REQ-027 A request accepted in the same cycle as mirror_wr uses the old mode; requests in later cycles use the new mode.
REQ-028 State machine has two states: INIT and RUN.
REQ-029 INIT: an 11-bit counter steps from 0 to 2047; each cycle writes 0 to nametable[counter] and to palette[counter[4:0]]; ready=0.
REQ-030 INIT to RUN transition occurs on the cycle the counter equals 2047; ready=1 from the following cycle.
REQ-031 When INIT_CLEAR=0, the block enters RUN directly after reset.
REQ-032 RUN: ready=1 permanently.
REQ-033 Pattern memory is never cleared by INIT.
REQ-034 mirror_wr is honoured in both INIT and RUN.

Reset
REQ-035 While rst=1: state=INIT (INIT_CLEAR=1) or RUN (INIT_CLEAR=0); counter=0; ready=0; dout=0x00; dout_valid=0; mode register=MIRROR_RESET.
REQ-036 rst asserted mid-INIT restarts the counter at 0.
REQ-037 rst asserted mid-RUN discards any in-flight read, so dout_valid=0 in the next cycle.
REQ-038 Memory contents other than those cleared by INIT are preserved across reset.

Verification
REQ-039 Reset release with INIT_CLEAR=1 -> ready=0 for exactly 2048 cycles, then 1; a read of 0x2000 and of 0x3F1F returns 0x00.
REQ-040 Vertical mode; write 0xA5 to 0x2005; read 0x2805 -> 0xA5; read 0x2405 -> 0x00; switch to horizontal; read 0x2405 -> 0xA5.
REQ-041 Write 0x3C to 0x3F10; read 0x3F00 -> 0x3C; write 0x11 to 0x3F14; read 0x3F04 -> 0x11; read 0x3F11 -> unaffected.
REQ-042 CHR_RAM=0: write 0x77 to 0x0123, then read 0x0123 -> preloaded value unchanged; CHR_RAM=1 -> 0x77.
REQ-043 Back-to-back reads of 0x2000, 0x2001, 0x2002 in three cycles -> dout_valid high for three consecutive cycles with the data in order; mirror_wr in the same cycle as the second read -> the second read still uses the old mode.
REQ-044 rst pulse at counter=1000 -> ready stays 0 for 2048 further cycles; req while ready=0 -> no dout_valid.
